parallel_stream_tx: RTL and testbench
=====================================

Name: parallel_stream_tx

Overview:
Parametrised byte-stream transmitter that buffers words in an internal circular FIFO and plays them out over a parallel bus to an external receiver (e.g. Arduino header) with a data strobe.
- Strobe timing is generated from the fast board clock by a programmable divider, instead of clocking the CPU off a divided clock.
- Supports optional 4-phase ack handshake, length/NUL termination, abort/flush, and overflow/timeout status.
- Sits between the memory read port (fill side) and the ARDUINO_IO pins.

Parameters:
DATA_W, 8, width of one transmitted word
DEPTH, 1024, FIFO entries (power of two)
ADDR_W, 10, log2(DEPTH)
DIV, 32, ADC_CLK_10 cycles per setup phase and per strobe phase (>=1)
HANDSHAKE, 0, 1 = strobe held until tx_ack (4-phase), 0 = fixed-width strobe
ACK_TIMEOUT, 65535, cycles waited for each ack edge before error (HANDSHAKE=1 only)

Ports:
ADC_CLK_10  in  1  clock
rst  in  1  reset
wr_en  in  1  push wr_data into FIFO
wr_data  in  DATA_W  fill data
flush  in  1  empty FIFO (IDLE only, ignored otherwise)
start  in  1  begin stream (sampled in IDLE)
term_mode  in  2  0 length, 1 NUL, 2 first of either, 3 treated as 2
length  in  ADDR_W+1  words to send in length modes, latched at start
abort  in  1  stop stream, return to IDLE
tx_ack  in  1  receiver acknowledge (async, 2-FF synchronised internally)
tx_data  out  DATA_W  parallel data
tx_strobe  out  1  data-valid strobe
busy  out  1  not IDLE
done  out  1  one-cycle pulse at stream end
level  out  ADDR_W+1  FIFO occupancy
full  out  1  level == DEPTH
overflow  out  1  sticky: write dropped while full
timeout  out  1  sticky: ack timeout occurred
sent  out  ADDR_W+1  words sent in current/last stream

Behaviour:
- Reset rst: asynchronous, active-high; clock ADC_CLK_10. Reset clears all pointers and counters; state IDLE; all outputs 0.
- FIFO:
  - Circular buffer, wr_ptr/rd_ptr ADDR_W bits wrapping DEPTH-1 -> 0; level ADDR_W+1 bits.
  - Write accepted when !full, or when full and a pop occurs the same cycle.
  - A rejected write sets overflow; data is not stored.
  - Simultaneous push and pop: level unchanged.
  - flush in IDLE: pointers and level to 0. overflow/timeout clear only on start or rst.
- States: IDLE, SETUP, STROBE, ACK_HI, ACK_LO, DONE.
- IDLE:
  - start=1 -> latch length and term_mode, clear sent/overflow/timeout.
  - length mode with length=0 -> DONE; otherwise -> SETUP.
- SETUP:
  - Stalls while level==0 (underrun; tx_data holds, strobe low, no timeout).
  - When level>0: pop head into tx_data, sent+1, divider loads DIV; stay DIV cycles -> STROBE.
- STROBE: tx_strobe=1. Next state:
  - HANDSHAKE=0: after DIV cycles -> end check.
  - HANDSHAKE=1: -> ACK_HI.
- ACK_HI: strobe held until synchronised ack=1, then strobe drops -> ACK_LO.
- ACK_LO: wait for ack=0 -> end check.
- Timeout: each ack wait counts up to ACK_TIMEOUT; expiry sets timeout, strobe 0 -> DONE.
- End check:
  - Stream ends when the word just sent ==0 (NUL modes; the terminator IS transmitted), or sent==latched length (length modes).
  - On end -> DONE; otherwise -> SETUP.
- DONE: done=1 for one cycle -> IDLE. busy=0 in IDLE only.
- Timing, HANDSHAKE=0: first tx_data valid 1 cycle after start with data present; each word occupies exactly 2*DIV cycles; tx_data stable for the whole strobe-high window.
- abort in any non-IDLE state: next cycle IDLE, strobe 0, no done pulse, FIFO contents retained.
- start while busy: ignored. wr_en is allowed while streaming.
- tx_data holds its last value after the stream ends.

Test Plan:
- Reset mid-stream (assert rst during STROBE) -> next edge tx_strobe=0, busy=0, level=0, sent=0, tx_data=0.
- Push 0x48,0x49,0x00,0x55; term_mode=1, DIV=4, start -> three words output, each strobe 4 cycles high after 4 setup cycles; done pulse after third; level=1 (0x55 remains), sent=3.
- Fill 1024 words, push one more -> full=1, overflow=1, level=1024; then stream term_mode=0 length=1024 -> pointer wraps, sent=1024, level=0, done once.
- HANDSHAKE=1: receiver raises ack 10 cycles after strobe and drops it 5 cycles after strobe falls -> strobe high until synced ack, next SETUP only after ack low; with ack never raised and ACK_TIMEOUT=100 -> timeout=1, done after 100 cycles.
- Underrun: start with level=0, length=2, push a word 50 cycles later -> busy held, strobe low meanwhile; first strobe DIV cycles after push.
- abort during ACK_HI with 5 words queued -> IDLE next cycle, no done, level=4 kept; flush -> level=0.

Source files
------------

// File: rtl/parallel_stream_tx.sv
// parallel_stream_tx: buffers fill-side words in a circular FIFO and plays
// them out on a parallel bus with a data strobe. Strobe timing comes from a
// divider on ADC_CLK_10, with an optional 4-phase ack handshake.
//
// Handshake (receiver side): tx_data is stable from the SETUP pop through the
// end of the strobe-high window. With HANDSHAKE=0 the strobe is high for DIV
// cycles. With HANDSHAKE=1 the strobe stays high until the synchronised
// tx_ack is seen high. The next word is presented only after tx_ack returns
// low. Each ack wait is bounded by ACK_TIMEOUT cycles.
module parallel_stream_tx #(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 1024,
  parameter int ADDR_W      = 10,
  parameter int DIV         = 32,
  parameter int HANDSHAKE   = 0,
  parameter int ACK_TIMEOUT = 65535
) (
  input  logic              ADC_CLK_10,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  input  logic              start,
  input  logic [1:0]        term_mode,
  input  logic [ADDR_W:0]   length,
  input  logic              abort,
  input  logic              tx_ack,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_strobe,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   level,
  output logic              full,
  output logic              overflow,
  output logic              timeout,
  output logic [ADDR_W:0]   sent,
  output logic [2:0]        fsm_state
);

  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TO_W  = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(ACK_TIMEOUT - 1);
  localparam logic [ADDR_W:0]   DEPTH_LVL = (ADDR_W+1)'(DEPTH);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    ACK_HI = 3'd3,
    ACK_LO = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t state, state_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic              have_word;
  logic [DIV_W-1:0]  div_cnt;
  logic [TO_W-1:0]   to_cnt;
  logic              ack_s1, ack_s2;
  logic [ADDR_W:0]   len_q;
  logic [1:0]        mode_q;

  logic pop, push, flush_now, start_now, set_timeout, to_clr;
  logic nul_mode, len_mode, stream_end;

  assign full      = (level == DEPTH_LVL);
  assign busy      = (state != IDLE);
  assign fsm_state = state;

  // End-of-stream decision for the word currently on tx_data.
  always_comb begin
    nul_mode   = (mode_q != 2'd0);
    len_mode   = (mode_q != 2'd1);
    stream_end = (nul_mode && (tx_data == '0)) || (len_mode && (sent == len_q));
  end

  // Next-state logic plus FIFO pop/push strobes.
  always_comb begin
    state_d     = state;
    pop         = 1'b0;
    start_now   = 1'b0;
    set_timeout = 1'b0;
    to_clr      = 1'b0;
    flush_now   = flush && (state == IDLE);
    case (state)
      IDLE: begin
        if (start && !flush) begin
          start_now = 1'b1;
          if ((term_mode != 2'd1) && (length == '0)) begin
            state_d = DONE;
          end else begin
            state_d = SETUP;
            pop     = (level != '0);
          end
        end
      end
      SETUP: begin
        if (!have_word) begin
          pop = (level != '0);
        end else if (div_cnt == '0) begin
          state_d = STROBE;
        end
      end
      STROBE: begin
        if (HANDSHAKE != 0) begin
          state_d = ACK_HI;
          to_clr  = 1'b1;
        end else if (div_cnt == '0) begin
          if (stream_end) begin
            state_d = DONE;
          end else begin
            state_d = SETUP;
            pop     = (level != '0);
          end
        end
      end
      ACK_HI: begin
        if (ack_s2) begin
          state_d = ACK_LO;
          to_clr  = 1'b1;
        end else if (to_cnt == TO_LAST) begin
          set_timeout = 1'b1;
          state_d     = DONE;
        end
      end
      ACK_LO: begin
        if (!ack_s2) begin
          if (stream_end) begin
            state_d = DONE;
          end else begin
            state_d = SETUP;
            pop     = (level != '0);
          end
        end else if (to_cnt == TO_LAST) begin
          set_timeout = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (abort && (state != IDLE)) begin
      state_d     = IDLE;
      pop         = 1'b0;
      set_timeout = 1'b0;
    end
    push = wr_en && (!full || pop) && !flush_now;
  end

  // State register.
  always_ff @(posedge ADC_CLK_10 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Two-flop synchroniser for the asynchronous receiver acknowledge.
  always_ff @(posedge ADC_CLK_10 or posedge rst) begin
    if (rst) begin
      ack_s1 <= 1'b0;
      ack_s2 <= 1'b0;
    end else begin
      ack_s1 <= tx_ack;
      ack_s2 <= ack_s1;
    end
  end

  // FIFO storage; the array itself carries no reset.
  always_ff @(posedge ADC_CLK_10) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge ADC_CLK_10 or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (flush_now) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Output word, phase divider, ack-wait counter and stream bookkeeping.
  always_ff @(posedge ADC_CLK_10 or posedge rst) begin
    if (rst) begin
      tx_data   <= '0;
      have_word <= 1'b0;
      div_cnt   <= '0;
      to_cnt    <= '0;
      sent      <= '0;
      len_q     <= '0;
      mode_q    <= 2'd0;
    end else begin
      if (pop) tx_data <= mem[rd_ptr];

      if (pop)                   have_word <= 1'b1;
      else if (state_d != SETUP) have_word <= 1'b0;

      if (pop)                                      div_cnt <= DIV_LAST;
      else if ((state_d == STROBE) && (state != STROBE)) div_cnt <= DIV_LAST;
      else if (div_cnt != '0)                       div_cnt <= div_cnt - 1'b1;

      if (to_clr)                                    to_cnt <= '0;
      else if ((state == ACK_HI) || (state == ACK_LO)) to_cnt <= to_cnt + 1'b1;

      if (start_now) begin
        sent   <= {{ADDR_W{1'b0}}, pop};
        len_q  <= length;
        mode_q <= term_mode;
      end else if (pop) begin
        sent <= sent + 1'b1;
      end
    end
  end

  // Sticky status flags and registered strobe/done outputs.
  always_ff @(posedge ADC_CLK_10 or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      timeout   <= 1'b0;
      tx_strobe <= 1'b0;
      done      <= 1'b0;
    end else begin
      if (wr_en && !push && !flush_now) overflow <= 1'b1;
      else if (start_now)               overflow <= 1'b0;

      if (set_timeout)    timeout <= 1'b1;
      else if (start_now) timeout <= 1'b0;

      tx_strobe <= (state_d == STROBE) || (state_d == ACK_HI);
      done      <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_parallel_stream_tx.sv
// Directed bench for parallel_stream_tx: one fixed-strobe instance (DIV=4)
// and one handshake instance (DIV=4, ACK_TIMEOUT=100).
module tb_parallel_stream_tx;
  localparam int AW = 10;

  logic clk, rst;

  logic          wr_en, flush, start, abort, tx_ack;
  logic [7:0]    wr_data;
  logic [1:0]    term_mode;
  logic [AW:0]   length;
  logic [7:0]    tx_data;
  logic          tx_strobe, busy, done, full, overflow, timeout;
  logic [AW:0]   level, sent;
  logic [2:0]    fsm_state;

  logic          h_wr_en, h_flush, h_start, h_abort, h_tx_ack;
  logic [7:0]    h_wr_data;
  logic [1:0]    h_term_mode;
  logic [AW:0]   h_length;
  logic [7:0]    h_tx_data;
  logic          h_tx_strobe, h_busy, h_done, h_full, h_overflow, h_timeout;
  logic [AW:0]   h_level, h_sent;
  logic [2:0]    h_fsm_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q[$];
  int rise_q[$];
  int fall_q[$];
  int width_q[$];
  int done_c;
  int unstable;

  parallel_stream_tx #(.DATA_W(8), .DEPTH(1024), .ADDR_W(AW), .DIV(4),
                       .HANDSHAKE(0), .ACK_TIMEOUT(100)) u_dut (
    .ADC_CLK_10(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .flush(flush), .start(start), .term_mode(term_mode), .length(length),
    .abort(abort), .tx_ack(tx_ack), .tx_data(tx_data), .tx_strobe(tx_strobe),
    .busy(busy), .done(done), .level(level), .full(full),
    .overflow(overflow), .timeout(timeout), .sent(sent), .fsm_state(fsm_state)
  );

  parallel_stream_tx #(.DATA_W(8), .DEPTH(1024), .ADDR_W(AW), .DIV(4),
                       .HANDSHAKE(1), .ACK_TIMEOUT(100)) u_dut_hs (
    .ADC_CLK_10(clk), .rst(rst), .wr_en(h_wr_en), .wr_data(h_wr_data),
    .flush(h_flush), .start(h_start), .term_mode(h_term_mode), .length(h_length),
    .abort(h_abort), .tx_ack(h_tx_ack), .tx_data(h_tx_data), .tx_strobe(h_tx_strobe),
    .busy(h_busy), .done(h_done), .level(h_level), .full(h_full),
    .overflow(h_overflow), .timeout(h_timeout), .sent(h_sent), .fsm_state(h_fsm_state)
  );

  // Clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push0(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d; tick(); wr_en = 1'b0;
  endtask

  task automatic start0(input logic [1:0] m, input logic [AW:0] n);
    term_mode = m; length = n; start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic push_h(input logic [7:0] d);
    h_wr_en = 1'b1; h_wr_data = d; tick(); h_wr_en = 1'b0;
  endtask

  task automatic start_h(input logic [1:0] m, input logic [AW:0] n);
    h_term_mode = m; h_length = n; h_start = 1'b1; tick(); h_start = 1'b0;
  endtask

  // Watch the fixed-strobe instance until done (or bound cycles); scoreboard
  // each word at its strobe rise against exp_q.
  task automatic watch0(input int bound);
    logic prev;
    logic [7:0] cur;
    int hi;
    rise_q.delete(); width_q.delete();
    done_c = -1; unstable = 0; hi = 0;
    prev = tx_strobe; cur = tx_data;
    for (int c = 1; c <= bound && done_c < 0; c++) begin
      tick();
      if (tx_strobe && !prev) begin
        rise_q.push_back(c);
        cur = tx_data;
        if (exp_q.size() > 0) check_eq("word", tx_data, exp_q.pop_front());
      end
      if (tx_strobe && (tx_data !== cur)) unstable++;
      if (tx_strobe) hi++;
      if (!tx_strobe && prev) begin
        width_q.push_back(hi);
        hi = 0;
      end
      if (done) done_c = c;
      prev = tx_strobe;
    end
  endtask

  // Watch the handshake instance, optionally acting as the receiver:
  // ack rises 10 cycles after strobe rises, falls 5 cycles after strobe falls.
  task automatic watch_h(input int bound, input bit respond);
    logic prev;
    int last_rise, last_fall;
    rise_q.delete(); fall_q.delete();
    done_c = -1; last_rise = -100; last_fall = -100;
    prev = h_tx_strobe;
    for (int c = 1; c <= bound && done_c < 0; c++) begin
      tick();
      if (h_tx_strobe && !prev) begin
        rise_q.push_back(c);
        last_rise = c;
        if (exp_q.size() > 0) check_eq("hs_word", h_tx_data, exp_q.pop_front());
      end
      if (!h_tx_strobe && prev) begin
        fall_q.push_back(c);
        last_fall = c;
      end
      if (respond && (c == last_rise + 10)) h_tx_ack = 1'b1;
      if (respond && (c == last_fall + 5))  h_tx_ack = 1'b0;
      if (h_done) done_c = c;
      prev = h_tx_strobe;
    end
  endtask

  initial begin
    int rc;
    int low_busy, hi_strobe, done_seen;
    rst = 1'b1;
    wr_en = 0; wr_data = 0; flush = 0; start = 0; term_mode = 0; length = 0; abort = 0; tx_ack = 0;
    h_wr_en = 0; h_wr_data = 0; h_flush = 0; h_start = 0; h_term_mode = 0; h_length = 0;
    h_abort = 0; h_tx_ack = 0;
    repeat (3) tick();

    // Reset state.
    check_eq("rst_strobe", tx_strobe, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_sent", sent, 0);
    check_eq("rst_data", tx_data, 0);
    check_eq("rst_flags", {full, overflow, timeout, done}, 0);
    check_eq("rst_hs_busy", h_busy, 0);
    rst = 1'b0;
    tick();

    // NUL termination: 0x48 0x49 0x00 sent, 0x55 stays queued.
    push0(8'h48); push0(8'h49); push0(8'h00); push0(8'h55);
    exp_q.push_back(8'h48); exp_q.push_back(8'h49); exp_q.push_back(8'h00);
    check_eq("nul_level_before", level, 4);
    start0(2'd1, 11'd0);
    check_eq("nul_first_data", tx_data, 8'h48);
    check_eq("nul_first_strobe", tx_strobe, 0);
    check_eq("nul_busy", busy, 1);
    watch0(60);
    check_eq("nul_words", rise_q.size(), 3);
    foreach (rise_q[i]) check_eq("nul_rise", rise_q[i], 4 + 8 * i);
    foreach (width_q[i]) check_eq("nul_width", width_q[i], 4);
    check_eq("nul_done_at", done_c, 24);
    check_eq("nul_stable", unstable, 0);
    check_eq("nul_sent", sent, 3);
    check_eq("nul_level", level, 1);
    tick();
    check_eq("nul_idle_busy", busy, 0);
    check_eq("nul_done_once", done, 0);

    // Length mode with length 0 finishes at once without popping.
    start0(2'd0, 11'd0);
    check_eq("len0_done", done, 1);
    check_eq("len0_level", level, 1);
    check_eq("len0_sent", sent, 0);
    tick();
    check_eq("len0_idle", busy, 0);

    // Flush in IDLE.
    flush = 1'b1; tick(); flush = 1'b0;
    check_eq("flush_level", level, 0);

    // Short length-mode stream to offset the pointers before the wrap test.
    push0(8'h11); push0(8'h22); push0(8'h33);
    exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
    start0(2'd0, 11'd3);
    watch0(60);
    check_eq("len3_words", rise_q.size(), 3);
    check_eq("len3_done_at", done_c, 24);
    check_eq("len3_sent", sent, 3);
    check_eq("len3_level", level, 0);
    tick();

    // Fill to full, one extra write overflows; stream all 1024 across the wrap.
    for (int i = 0; i < 1024; i++) begin
      push0(8'(i));
      exp_q.push_back(8'(i));
    end
    check_eq("fill_full", full, 1);
    check_eq("fill_ovf_clear", overflow, 0);
    push0(8'hEE);
    check_eq("fill_level", level, 1024);
    check_eq("fill_overflow", overflow, 1);
    start0(2'd0, 11'd1024);
    check_eq("big_ovf_cleared", overflow, 0);
    watch0(9000);
    check_eq("big_words", rise_q.size(), 1024);
    check_eq("big_last_rise", (rise_q.size() > 0) ? rise_q[rise_q.size()-1] : -1, 8188);
    check_eq("big_done_at", done_c, 8192);
    check_eq("big_stable", unstable, 0);
    check_eq("big_sent", sent, 1024);
    check_eq("big_level", level, 0);
    check_eq("big_full", full, 0);
    check_eq("big_exp_left", exp_q.size(), 0);
    tick();
    check_eq("big_done_once", done, 0);

    // Underrun: stream of 2 started with an empty FIFO.
    start0(2'd0, 11'd2);
    check_eq("ur_hold_data", tx_data, 8'hFF);
    low_busy = 0; hi_strobe = 0;
    for (int c = 0; c < 50; c++) begin
      tick();
      if (!busy) low_busy++;
      if (tx_strobe) hi_strobe++;
    end
    check_eq("ur_busy_held", low_busy, 0);
    check_eq("ur_strobe_low", hi_strobe, 0);
    check_eq("ur_no_timeout", timeout, 0);
    push0(8'h5A);
    rc = -1;
    for (int c = 1; c <= 20 && rc < 0; c++) begin
      tick();
      if (tx_strobe) begin
        rc = c;
        check_eq("ur_word", tx_data, 8'h5A);
      end
    end
    check_eq("ur_rise", rc, 5);
    push0(8'h5B);
    exp_q.push_back(8'h5B);
    watch0(60);
    check_eq("ur_second_word", rise_q.size(), 1);
    check_eq("ur_done", (done_c > 0) ? 1 : 0, 1);
    check_eq("ur_sent", sent, 2);
    tick();

    // Handshake: receiver acks 10 cycles after rise, releases 5 after fall.
    push_h(8'hA1); push_h(8'hB2);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hB2);
    start_h(2'd0, 11'd2);
    watch_h(200, 1'b1);
    check_eq("hs_rises", rise_q.size(), 2);
    check_eq("hs_falls", fall_q.size(), 2);
    if (rise_q.size() == 2 && fall_q.size() == 2) begin
      check_eq("hs_rise0", rise_q[0], 4);
      check_eq("hs_fall0", fall_q[0], 17);
      check_eq("hs_rise1", rise_q[1], 29);
      check_eq("hs_fall1", fall_q[1], 42);
    end
    check_eq("hs_done_at", done_c, 50);
    check_eq("hs_sent", h_sent, 2);
    check_eq("hs_no_timeout", h_timeout, 0);
    tick();

    // Handshake timeout: ack never arrives.
    push_h(8'hC3);
    exp_q.push_back(8'hC3);
    start_h(2'd0, 11'd1);
    watch_h(300, 1'b0);
    check_eq("to_rise", (rise_q.size() > 0) ? rise_q[0] : -1, 4);
    check_eq("to_done_at", done_c, 105);
    check_eq("to_strobe_low", h_tx_strobe, 0);
    check_eq("to_flag", h_timeout, 1);
    tick();

    // Abort during ACK_HI with 5 words queued.
    for (int i = 0; i < 5; i++) push_h(8'(8'h60 + i));
    start_h(2'd0, 11'd5);
    repeat (8) tick();
    check_eq("ab_state", h_fsm_state, 3);
    check_eq("ab_strobe_hi", h_tx_strobe, 1);
    h_abort = 1'b1; tick(); h_abort = 1'b0;
    check_eq("ab_busy", h_busy, 0);
    check_eq("ab_strobe", h_tx_strobe, 0);
    check_eq("ab_level", h_level, 4);
    done_seen = h_done ? 1 : 0;
    repeat (4) begin
      tick();
      if (h_done) done_seen++;
    end
    check_eq("ab_no_done", done_seen, 0);
    h_flush = 1'b1; tick(); h_flush = 1'b0;
    check_eq("ab_flush_level", h_level, 0);

    // Reset asserted while the strobe is high.
    push0(8'h77); push0(8'h78);
    start0(2'd0, 11'd2);
    rc = 0;
    for (int c = 0; c < 20 && !tx_strobe; c++) begin
      tick();
      rc++;
    end
    check_eq("mr_strobe_before", tx_strobe, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("mr_strobe", tx_strobe, 0);
    check_eq("mr_busy", busy, 0);
    check_eq("mr_level", level, 0);
    check_eq("mr_sent", sent, 0);
    check_eq("mr_data", tx_data, 0);
    #2 rst = 1'b0;
    tick();
    check_eq("mr_idle_after", busy, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
